// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store bridge from the execute stage to two memory
// regions. North is a narrow multi-beat bus with a ready handshake; local
// is full width with a fixed single-cycle access. The effective address
// bit LOCAL_BIT picks the region. Loads are assembled, then sign- or
// zero-extended into rsp_data. Misaligned or illegal-size accesses finish
// with rsp_err and touch no memory.
module mem_access_unit #(
  parameter int XLEN        = 32,
  parameter int NB_W        = 16,
  parameter int LOCAL_BIT   = 24,
  parameter int CHECK_ALIGN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_load,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] n_addr,
  output logic [NB_W-1:0] n_wdata,
  input  logic [NB_W-1:0] n_rdata,
  output logic            n_read,
  output logic            n_write,
  input  logic            n_rdy,
  output logic [XLEN-1:0] l_addr,
  output logic [XLEN-1:0] l_wdata,
  input  logic [XLEN-1:0] l_rdata,
  output logic            l_read,
  output logic            l_write,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic            busy
);

  // Number of north lanes in one register, beat counter width, and the
  // shift that turns a byte address into a north word index.
  localparam int MAXB = XLEN / NB_W;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int NSH  = $clog2(NB_W / 8);

  typedef enum logic [2:0] {IDLE, N_XFER, L_ACC, L_CAP, DONE} state_t;

  // Control fields latched at acceptance.
  typedef struct packed {
    logic       load;
    logic [1:0] size;
    logic       uns;
    logic       err;
  } ctl_t;

  state_t state, state_nx;
  ctl_t   ctl_q;

  logic [XLEN-1:0]            ea_q;
  logic [MAXB-1:0][NB_W-1:0]  wd_lanes;
  logic [MAXB-1:0][NB_W-1:0]  rd_lanes;
  logic [MAXB-1:0][NB_W-1:0]  asm_data;
  logic [BW-1:0]              beat;
  logic [BW-1:0]              last_q;
  logic [XLEN-1:0]            rsp_data_q;

  logic [XLEN-1:0] ea_calc;
  logic [2:0]      amask;
  logic            size_bad;
  logic            misalign;
  logic            req_bad;
  logic            accept;
  logic            beat_done;

  // Zero/sign extension from the accessed width; the fill bit comes only
  // from the data handed in, so each region supplies its own sign.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [1:0]      sz,
                                             input logic            uns);
    logic [XLEN-1:0] r;
    logic            fill;
    int              w;
    w = 8 << sz;
    if (w > XLEN) w = XLEN;
    case (sz)
      2'd0:    fill = d[7];
      2'd1:    fill = d[15];
      2'd2:    fill = d[31];
      default: fill = d[XLEN-1];
    endcase
    if (uns) fill = 1'b0;
    for (int i = 0; i < XLEN; i++) r[i] = (i < w) ? d[i] : fill;
    return r;
  endfunction

  // Index of the final north beat for a given size; sub-lane accesses
  // still take one beat on the low lanes.
  function automatic logic [BW-1:0] last_of(input logic [1:0] sz);
    int n;
    n = (8 << sz) / NB_W;
    if (n < 1) n = 1;
    if (n > MAXB) n = MAXB;
    return BW'(n - 1);
  endfunction

  // Effective address and request legality, evaluated on the raw inputs.
  always_comb begin
    ea_calc = base + imm;
    case (req_size)
      2'd0:    amask = 3'b000;
      2'd1:    amask = 3'b001;
      2'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
    size_bad = (req_size == 2'd3) && (XLEN < 64);
    misalign = (CHECK_ALIGN != 0) && ((ea_calc[2:0] & amask) != 3'b000);
    req_bad  = size_bad || misalign;
  end

  // Load data as it will look once the current north beat lands.
  always_comb begin
    asm_data       = rd_lanes;
    asm_data[beat] = n_rdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and strobe decode; every output is forced quiet outside
  // the state that owns it.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    beat_done = 1'b0;
    req_ready = 1'b0;
    n_addr    = '0;
    n_wdata   = '0;
    n_read    = 1'b0;
    n_write   = 1'b0;
    l_addr    = '0;
    l_wdata   = '0;
    l_read    = 1'b0;
    l_write   = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && (req_load || req_store)) begin
          accept = 1'b1;
          if (req_bad)                 state_nx = DONE;
          else if (ea_calc[LOCAL_BIT]) state_nx = L_ACC;
          else                         state_nx = N_XFER;
        end
      end
      N_XFER: begin
        n_read  = ctl_q.load;
        n_write = ~ctl_q.load;
        n_addr  = (ea_q >> NSH) + XLEN'(beat);
        n_wdata = ctl_q.load ? '0 : wd_lanes[beat];
        if (n_rdy) begin
          beat_done = 1'b1;
          if (beat == last_q) state_nx = DONE;
        end
      end
      L_ACC: begin
        l_read   = ctl_q.load;
        l_write  = ~ctl_q.load;
        l_addr   = ea_q;
        l_wdata  = wd_lanes;
        state_nx = ctl_q.load ? L_CAP : DONE;
      end
      L_CAP: state_nx = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = ctl_q.err;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, beat sequencing and load result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q      <= '0;
      ea_q       <= '0;
      wd_lanes   <= '0;
      rd_lanes   <= '0;
      beat       <= '0;
      last_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        ctl_q.load <= req_load;
        ctl_q.size <= req_size;
        ctl_q.uns  <= req_unsigned;
        ctl_q.err  <= req_bad;
        ea_q       <= ea_calc;
        wd_lanes   <= wdata;
        rd_lanes   <= '0;
        beat       <= '0;
        last_q     <= last_of(req_size);
      end
      if (beat_done) begin
        if (ctl_q.load) rd_lanes[beat] <= n_rdata;
        beat <= beat + BW'(1);
        if (ctl_q.load && (beat == last_q))
          rsp_data_q <= extend(asm_data, ctl_q.size, ctl_q.uns);
      end
      if (state == L_CAP)
        rsp_data_q <= extend(l_rdata, ctl_q.size, ctl_q.uns);
    end
  end

  assign rsp_data = rsp_data_q;
  assign busy     = ~req_ready;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store bridge between the CPU execute stage and two memory regions.
- North region: narrow external bus, multi-beat, ready-handshaked. Local region: full-width, fixed single-cycle access.
- Computes effective address, selects region by one address bit, splits/merges multi-beat transfers, sign/zero-extends loads, flags misaligned accesses.
- Successor of the 32/16-bit fixed interface: widths, region bit and beat count are generic; adds error reporting and back-to-back request acceptance.

Parameters:
XLEN, 32, register/data width in bits (multiple of 8; 32 or 64).
NB_W, 16, north bus data width; must divide XLEN, at least 8.
LOCAL_BIT, 24, effective-address bit; 1 selects local, 0 selects north.
CHECK_ALIGN, 1, 1 enables the misalignment error; 0 disables it.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_load  in  1  load request (has priority if req_store is also set)
req_store  in  1  store request
req_size  in  2  0=byte, 1=half, 2=word, 3=dword (3 is legal only if XLEN=64)
req_unsigned  in  1  zero-extend load (1) / sign-extend load (0)
base  in  XLEN  base register value
imm  in  XLEN  offset
wdata  in  XLEN  store data
n_addr  out  XLEN  north beat address (NB_W-wide word index)
n_wdata  out  NB_W  north write data
n_rdata  in  NB_W  north read data
n_read  out  1  north read strobe
n_write  out  1  north write strobe
n_rdy  in  1  north beat-accept / data-valid
l_addr  out  XLEN  local address (byte address)
l_wdata  out  XLEN  local write data
l_rdata  in  XLEN  local read data, valid the cycle after l_read
l_read  out  1  local read strobe
l_write  out  1  local write strobe
rsp_valid  out  1  one-cycle pulse: access complete
rsp_data  out  XLEN  extended load result; held until the next rsp_valid
rsp_err  out  1  qualifies rsp_valid: misaligned or illegal size, no memory access made
busy  out  1  equals NOT req_ready

Behaviour:
- Reset (rst high at a clk edge): state IDLE; all strobes 0; n_addr, l_addr, n_wdata, l_wdata, rsp_data = 0; rsp_valid = rsp_err = 0; req_ready = 1.
- Reset mid-transfer: abort immediately, no rsp_valid, strobes drop the next cycle.
- Acceptance: a request is accepted when req_valid & req_ready & (req_load | req_store). On acceptance, latch ea = base + imm (mod 2^XLEN), size, unsigned flag and wdata.
- Error check: if CHECK_ALIGN and ea is not size-aligned, or size is illegal, go to DONE with rsp_err = 1 and assert no strobes.
- Beats: BEATS = max(1, bytes(size)*8 / NB_W). A byte access with NB_W > 8 is one beat using the low lanes.
- States:
  - IDLE: accept a request; go to N_XFER (ea[LOCAL_BIT]=0), L_ACC (ea[LOCAL_BIT]=1), or DONE on error.
  - N_XFER:
    - n_read or n_write held high; n_addr = ea/(NB_W/8) + beat.
    - A beat completes at a clk edge with strobe=1 and n_rdy=1.
    - Read beat k stores n_rdata into bits [k*NB_W +: NB_W]. Write beat k drives wdata[k*NB_W +: NB_W].
    - After beat BEATS-1, strobe drops and state goes to DONE. n_rdy low stalls indefinitely with all outputs held.
  - L_ACC: one cycle; l_read/l_write = 1, l_addr = ea, l_wdata = wdata. Load goes to L_CAP; store goes to DONE.
  - L_CAP: capture l_rdata; go to DONE.
  - DONE: rsp_valid = 1 for one cycle; rsp_data updated for loads only; return to IDLE.
- Extension: sign source is the top bit of the accessed width taken from the assembled data (north or local), never from the other region.
- req_ready is 1 only in IDLE, so a new request can be accepted the cycle after DONE.
- Stores leave rsp_data unchanged; rsp_valid still pulses.
- Latency from accept edge to rsp_valid: local load 3 cycles, local store 2 cycles, north = BEATS + stall cycles + 1, error 1 cycle.
- A request with neither load nor store set is ignored; req_ready stays 1.

Test Plan:
- XLEN=32, NB_W=16: north word load, base=0x100, imm=4, n_rdata 0xBEEF then 0xDEAD, n_rdy=1 -> n_addr 0x82 then 0x83; rsp_data=0xDEADBEEF; rsp_valid on 3rd cycle after accept.
- North signed byte load with n_rdata=0x0080, req_unsigned=0 -> rsp_data=0xFFFFFF80. Same with req_unsigned=1 -> 0x00000080.
- Local signed half load at ea=0x01000002, l_rdata=0x12348001 -> rsp_data=0xFFFF8001 (sign from local data). rsp_valid exactly 3 cycles after accept.
- North word store wdata=0xCAFEF00D, n_rdy held low 4 cycles then high -> n_wdata 0xF00D then 0xCAFE; outputs stable during the stall; rsp_valid once; rsp_data unchanged.
- Misaligned word load at ea=0x102 -> rsp_valid and rsp_err = 1 one cycle after accept; no n_read or l_read pulse. Same access with CHECK_ALIGN=0 proceeds normally.
- rst asserted in the middle of a 2-beat north read -> next cycle n_read=0, req_ready=1, no rsp_valid; a new local load then completes normally.
